// File: rtl/trigger_chain_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// trigger_chain_wb_arbiter_if
//   One Wishbone classic bus segment, used for each master port and for the
//   target port of the trigger-chain arbiter.
//
//   Signals
//     cyc, stb, we   cycle, strobe, write enable        (master -> slave)
//     adr            address, ADDR_WIDTH bits           (master -> slave)
//     dat_w          write data, DATA_WIDTH bits        (master -> slave)
//     sel            byte selects, DATA_WIDTH/8 bits    (master -> slave)
//     ack, err, rty  cycle responses                    (slave -> master)
//     dat_r          read data, DATA_WIDTH bits         (slave -> master)
//
//   Modports
//     master  the side that initiates cycles
//     slave   the side that answers them
// ---------------------------------------------------------------------------
interface trigger_chain_wb_arbiter_if #(
   parameter int ADDR_WIDTH = 22,
   parameter int DATA_WIDTH = 32
) ();
   logic                    cyc;
   logic                    stb;
   logic                    we;
   logic [ADDR_WIDTH-1:0]   adr;
   logic [DATA_WIDTH-1:0]   dat_w;
   logic [DATA_WIDTH/8-1:0] sel;
   logic                    ack;
   logic                    err;
   logic                    rty;
   logic [DATA_WIDTH-1:0]   dat_r;

   modport master (
      output cyc, stb, we, adr, dat_w, sel,
      input  ack, err, rty, dat_r
   );

   modport slave (
      input  cyc, stb, we, adr, dat_w, sel,
      output ack, err, rty, dat_r
   );
endinterface

// File: rtl/trigger_chain_wb_arbiter.sv
// ---------------------------------------------------------------------------
// trigger_chain_wb_arbiter
//   Two-master, one-target Wishbone arbiter in front of the 8-channel
//   trigger-chain coefficient/AGC target port. Master 0 is the host register
//   path, master 1 the on-chip auto-servo / coefficient loader.
//
//   Ownership is round-robin, granted per cyc assertion and held until the
//   owner drops cyc. A watchdog aborts a strobe the target never answers and
//   returns err to the owning master for exactly one cycle.
//
//   Ports
//     wb_clk_i         Wishbone clock, the only clock
//     wb_rstn_i        reset, asynchronous assert, active low
//     m0, m1           master-facing buses (slave modport)
//     s                target-facing bus (master modport)
//     grant_o          one-hot owner: 01 = master 0, 10 = master 1, 00 idle
//     timeout_count_o  saturating count of watchdog aborts
// ---------------------------------------------------------------------------
module trigger_chain_wb_arbiter #(
   parameter int ADDR_WIDTH     = 22,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255   // legal range 2..65535
) (
   input  logic                              wb_clk_i,
   input  logic                              wb_rstn_i,
   trigger_chain_wb_arbiter_if.slave         m0,
   trigger_chain_wb_arbiter_if.slave         m1,
   trigger_chain_wb_arbiter_if.master        s,
   output logic [1:0]                        grant_o,
   output logic [7:0]                        timeout_count_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN0  = 2'd1,
      OWN1  = 2'd2,
      ABORT = 2'd3
   } state_t;

   localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state;
   logic        last_owner;    // 1 after reset so master 0 wins first contention
   logic        abort_owner;   // which master receives err during ABORT
   logic [15:0] wd_count;

   logic own0;
   logic own1;
   logic in_abort;
   logic any_resp;
   logic owner_cyc;

   assign own0     = (state == OWN0);
   assign own1     = (state == OWN1);
   assign in_abort = (state == ABORT);
   assign any_resp = s.ack | s.err | s.rty;
   assign grant_o  = {own1, own0};

   // ------------------------------------------------------------------------
   // Target-side mux: pure combinational path from the owner, so there is no
   // added latency once the grant is in place. Idle and ABORT drive zeros.
   // ------------------------------------------------------------------------
   logic                    cyc_mux;
   logic                    stb_mux;
   logic                    we_mux;
   logic [ADDR_WIDTH-1:0]   adr_mux;
   logic [DATA_WIDTH-1:0]   wdat_mux;
   logic [DATA_WIDTH/8-1:0] sel_mux;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first so
      // no path through the case leaves it unassigned and infers a latch.
      cyc_mux   = 1'b0;
      stb_mux   = 1'b0;
      we_mux    = 1'b0;
      adr_mux   = '0;
      wdat_mux  = '0;
      sel_mux   = '0;
      owner_cyc = 1'b0;
      case (state)
         OWN0: begin
            cyc_mux   = m0.cyc;
            stb_mux   = m0.stb;
            we_mux    = m0.we;
            adr_mux   = m0.adr;
            wdat_mux  = m0.dat_w;
            sel_mux   = m0.sel;
            owner_cyc = m0.cyc;
         end
         OWN1: begin
            cyc_mux   = m1.cyc;
            stb_mux   = m1.stb;
            we_mux    = m1.we;
            adr_mux   = m1.adr;
            wdat_mux  = m1.dat_w;
            sel_mux   = m1.sel;
            owner_cyc = m1.cyc;
         end
         default: ;
      endcase
   end

   assign s.cyc   = cyc_mux;
   assign s.stb   = stb_mux;
   assign s.we    = we_mux;
   assign s.adr   = adr_mux;
   assign s.dat_w = wdat_mux;
   assign s.sel   = sel_mux;

   // ------------------------------------------------------------------------
   // Response routing: only the owner sees the target. During ABORT the owner
   // gets err regardless of any late ack, which is simply dropped.
   // ------------------------------------------------------------------------
   assign m0.ack   = own0 & s.ack;
   assign m0.err   = (own0 & s.err) | (in_abort & ~abort_owner);
   assign m0.rty   = own0 & s.rty;
   assign m0.dat_r = own0 ? s.dat_r : '0;

   assign m1.ack   = own1 & s.ack;
   assign m1.err   = (own1 & s.err) | (in_abort & abort_owner);
   assign m1.rty   = own1 & s.rty;
   assign m1.dat_r = own1 ? s.dat_r : '0;

   // ------------------------------------------------------------------------
   // Arbitration FSM and watchdog.
   // ------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
      if (!wb_rstn_i) begin
         state           <= IDLE;
         last_owner      <= 1'b1;
         abort_owner     <= 1'b0;
         wd_count        <= '0;
         timeout_count_o <= '0;
      end else begin
         case (state)
            IDLE: begin
               wd_count <= '0;
               // Master 0 wins if alone, or if master 1 owned the bus last.
               if (m0.cyc && (!m1.cyc || last_owner)) begin
                  state      <= OWN0;
                  last_owner <= 1'b0;
               end else if (m1.cyc) begin
                  state      <= OWN1;
                  last_owner <= 1'b1;
               end
            end

            OWN0, OWN1: begin
               if (!owner_cyc) begin
                  // Owner release takes priority over a coincident timeout.
                  state    <= IDLE;
                  wd_count <= '0;
               end else if (s.stb && !any_resp) begin
                  if (wd_count == WD_LAST) begin
                     state       <= ABORT;
                     abort_owner <= own1;
                     wd_count    <= '0;
                     if (timeout_count_o != 8'hFF)
                        timeout_count_o <= timeout_count_o + 8'd1;
                  end else begin
                     wd_count <= wd_count + 16'd1;
                  end
               end else begin
                  // No strobe, or the target answered: the transfer is alive.
                  wd_count <= '0;
               end
            end

            ABORT: begin
               state    <= IDLE;
               wd_count <= '0;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_trigger_chain_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_trigger_chain_wb_arbiter
//   Directed bench for the two-master trigger-chain Wishbone arbiter.
//   The target is played by the bench; responses are placed on hand-chosen
//   cycles and every expectation is a hand-derived constant.
//   Watchdog length is reduced to 8 cycles so abort scenarios stay short.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_trigger_chain_wb_arbiter;

   localparam int AW = 22;
   localparam int DW = 32;
   localparam int TO = 8;

   logic       wb_clk_i  = 1'b0;
   logic       wb_rstn_i = 1'b0;
   logic [1:0] grant;
   logic [7:0] tcount;

   int n_checks = 0;
   int n_fail   = 0;

   trigger_chain_wb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0 ();
   trigger_chain_wb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1 ();
   trigger_chain_wb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s  ();

   trigger_chain_wb_arbiter #(
      .ADDR_WIDTH     (AW),
      .DATA_WIDTH     (DW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .wb_clk_i        (wb_clk_i),
      .wb_rstn_i       (wb_rstn_i),
      .m0              (m0),
      .m1              (m1),
      .s               (s),
      .grant_o         (grant),
      .timeout_count_o (tcount)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge wb_clk_i);
      #1;
   endtask

   task automatic idle_all();
      m0.cyc = 0; m0.stb = 0; m0.we = 0; m0.adr = '0; m0.dat_w = '0; m0.sel = '0;
      m1.cyc = 0; m1.stb = 0; m1.we = 0; m1.adr = '0; m1.dat_w = '0; m1.sel = '0;
      s.ack = 0; s.err = 0; s.rty = 0; s.dat_r = '0;
   endtask

   task automatic apply_reset();
      idle_all();
      wb_rstn_i = 1'b0;
      repeat (2) @(posedge wb_clk_i);
      @(negedge wb_clk_i);
      wb_rstn_i = 1'b1;
      step();
   endtask

   task automatic test_reset();
      idle_all();
      wb_rstn_i = 1'b0;
      #3;
      n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b want 00", grant); end
      n_checks++; if (tcount !== 8'd0) begin n_fail++; $display("FAIL reset_tcount: got %0d want 0", tcount); end
      n_checks++; if (s.cyc !== 1'b0 || s.stb !== 1'b0) begin n_fail++; $display("FAIL reset_s_ctl: cyc=%b stb=%b want 0 0", s.cyc, s.stb); end
      n_checks++; if ({m0.ack, m0.err, m0.rty, m1.ack, m1.err, m1.rty} !== 6'b0) begin n_fail++; $display("FAIL reset_resp: got %b want 000000", {m0.ack, m0.err, m0.rty, m1.ack, m1.err, m1.rty}); end
      @(negedge wb_clk_i);
      wb_rstn_i = 1'b1;
      step();
   endtask

   task automatic test_single_write();
      m0.cyc = 1; m0.stb = 1; m0.we = 1; m0.adr = 22'h000404; m0.dat_w = 32'hDEADBEEF; m0.sel = 4'hF;
      #1;
      n_checks++; if (s.cyc !== 1'b0 || grant !== 2'b00) begin n_fail++; $display("FAIL wr_no_same_cycle: cyc=%b grant=%b want 0 00", s.cyc, grant); end
      step();
      n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL wr_grant: got %b want 01", grant); end
      n_checks++; if (s.cyc !== 1'b1 || s.stb !== 1'b1 || s.we !== 1'b1) begin n_fail++; $display("FAIL wr_s_ctl: cyc=%b stb=%b we=%b want 111", s.cyc, s.stb, s.we); end
      n_checks++; if (s.adr !== 22'h000404 || s.dat_w !== 32'hDEADBEEF || s.sel !== 4'hF) begin n_fail++; $display("FAIL wr_s_payload: adr=%h dat=%h sel=%h want 000404 deadbeef f", s.adr, s.dat_w, s.sel); end
      n_checks++; if (m0.ack !== 1'b0) begin n_fail++; $display("FAIL wr_early_ack: got %b want 0", m0.ack); end
      step();
      step();
      s.ack = 1;
      #1;
      n_checks++; if (m0.ack !== 1'b1 || m1.ack !== 1'b0) begin n_fail++; $display("FAIL wr_ack_route: m0=%b m1=%b want 1 0", m0.ack, m1.ack); end
      step();
      m0.cyc = 0; m0.stb = 0; m0.we = 0; s.ack = 0;
      #1;
      n_checks++; if (m0.ack !== 1'b0 || s.cyc !== 1'b0) begin n_fail++; $display("FAIL wr_release: ack=%b cyc=%b want 0 0", m0.ack, s.cyc); end
      n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL wr_grant_held: got %b want 01", grant); end
      step();
      n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL wr_grant_idle: got %b want 00", grant); end
   endtask

   // Four contended reads; the former owner re-requests in the IDLE cycle,
   // so contention winners must alternate 0,1,0,1.
   task automatic test_round_robin();
      logic [1:0]  exp_g;
      logic [31:0] rd;
      logic        ow;
      apply_reset();
      m0.cyc = 1; m0.stb = 1; m0.we = 0; m0.adr = 22'h000100; m0.sel = 4'hF;
      m1.cyc = 1; m1.stb = 1; m1.we = 0; m1.adr = 22'h3FFFFF; m1.sel = 4'h3;
      for (int r = 0; r < 4; r++) begin
         ow    = r[0];
         exp_g = ow ? 2'b10 : 2'b01;
         rd    = 32'h11 * (r + 1);
         step();
         n_checks++; if (grant !== exp_g) begin n_fail++; $display("FAIL rr_grant round %0d: got %b want %b", r, grant, exp_g); end
         s.ack = 1; s.dat_r = rd;
         #1;
         if (!ow) begin
            n_checks++; if (m0.ack !== 1'b1 || m0.dat_r !== rd) begin n_fail++; $display("FAIL rr_m0_read round %0d: ack=%b dat=%h want 1 %h", r, m0.ack, m0.dat_r, rd); end
            n_checks++; if (m1.ack !== 1'b0 || m1.dat_r !== 32'h0) begin n_fail++; $display("FAIL rr_m1_isolated round %0d: ack=%b dat=%h want 0 0", r, m1.ack, m1.dat_r); end
            n_checks++; if (s.adr !== 22'h000100 || s.sel !== 4'hF) begin n_fail++; $display("FAIL rr_m0_payload round %0d: adr=%h sel=%h", r, s.adr, s.sel); end
         end else begin
            n_checks++; if (m1.ack !== 1'b1 || m1.dat_r !== rd) begin n_fail++; $display("FAIL rr_m1_read round %0d: ack=%b dat=%h want 1 %h", r, m1.ack, m1.dat_r, rd); end
            n_checks++; if (m0.ack !== 1'b0 || m0.dat_r !== 32'h0) begin n_fail++; $display("FAIL rr_m0_isolated round %0d: ack=%b dat=%h want 0 0", r, m0.ack, m0.dat_r); end
            n_checks++; if (s.adr !== 22'h3FFFFF || s.sel !== 4'h3) begin n_fail++; $display("FAIL rr_m1_payload round %0d: adr=%h sel=%h", r, s.adr, s.sel); end
         end
         step();
         if (!ow) begin m0.cyc = 0; m0.stb = 0; end else begin m1.cyc = 0; m1.stb = 0; end
         s.ack = 0; s.dat_r = '0;
         #1;
         n_checks++; if (s.cyc !== 1'b0 || grant !== exp_g) begin n_fail++; $display("FAIL rr_drop round %0d: cyc=%b grant=%b want 0 %b", r, s.cyc, grant, exp_g); end
         step();
         n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL rr_idle round %0d: got %b want 00", r, grant); end
         if (r < 3) begin
            if (!ow) begin m0.cyc = 1; m0.stb = 1; end else begin m1.cyc = 1; m1.stb = 1; end
         end else begin
            idle_all();
         end
      end
      step();
      n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL rr_final_idle: got %b want 00", grant); end
   endtask

   task automatic test_timeout_silent();
      m1.cyc = 1; m1.stb = 1; m1.we = 1; m1.adr = 22'h000200; m1.dat_w = 32'hCAFE0001; m1.sel = 4'hF;
      for (int k = 1; k <= TO; k++) begin
         step();
         n_checks++; if (grant !== 2'b10 || m1.err !== 1'b0) begin n_fail++; $display("FAIL to_wait cycle %0d: grant=%b err=%b want 10 0", k, grant, m1.err); end
      end
      step();
      n_checks++; if (s.cyc !== 1'b0 || s.stb !== 1'b0) begin n_fail++; $display("FAIL to_abort_s: cyc=%b stb=%b want 0 0", s.cyc, s.stb); end
      n_checks++; if (m1.err !== 1'b1 || m0.err !== 1'b0) begin n_fail++; $display("FAIL to_abort_err: m1=%b m0=%b want 1 0", m1.err, m0.err); end
      n_checks++; if (grant !== 2'b00 || tcount !== 8'd1) begin n_fail++; $display("FAIL to_abort_state: grant=%b count=%0d want 00 1", grant, tcount); end
      s.ack = 1;
      #1;
      n_checks++; if (m1.ack !== 1'b0 || m1.err !== 1'b1) begin n_fail++; $display("FAIL to_late_ack: ack=%b err=%b want 0 1", m1.ack, m1.err); end
      s.ack = 0; m1.cyc = 0; m1.stb = 0; m1.we = 0;
      step();
      n_checks++; if (m1.err !== 1'b0 || grant !== 2'b00) begin n_fail++; $display("FAIL to_after_abort: err=%b grant=%b want 0 00", m1.err, grant); end
   endtask

   task automatic test_timeout_ack_wins();
      m1.cyc = 1; m1.stb = 1; m1.we = 0; m1.adr = 22'h000300;
      for (int k = 1; k < TO; k++) step();
      step();
      s.ack = 1; s.dat_r = 32'h5A5A5A5A;
      #1;
      n_checks++; if (m1.ack !== 1'b1 || m1.err !== 1'b0 || m1.dat_r !== 32'h5A5A5A5A) begin n_fail++; $display("FAIL ta_ack: ack=%b err=%b dat=%h want 1 0 5a5a5a5a", m1.ack, m1.err, m1.dat_r); end
      step();
      m1.cyc = 0; m1.stb = 0; s.ack = 0; s.dat_r = '0;
      #1;
      n_checks++; if (grant !== 2'b10 || m1.err !== 1'b0) begin n_fail++; $display("FAIL ta_no_abort: grant=%b err=%b want 10 0", grant, m1.err); end
      n_checks++; if (tcount !== 8'd1) begin n_fail++; $display("FAIL ta_count: got %0d want 1", tcount); end
      step();
      n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL ta_idle: got %b want 00", grant); end
   endtask

   task automatic test_drop_at_threshold();
      m0.cyc = 1; m0.stb = 1; m0.we = 0; m0.adr = 22'h000010;
      repeat (TO) step();
      m0.cyc = 0;
      #1;
      n_checks++; if (s.cyc !== 1'b0) begin n_fail++; $display("FAIL dt_cyc_drop: got %b want 0", s.cyc); end
      step();
      m0.stb = 0;
      #1;
      n_checks++; if (grant !== 2'b00 || m0.err !== 1'b0 || tcount !== 8'd1) begin n_fail++; $display("FAIL dt_no_abort: grant=%b err=%b count=%0d want 00 0 1", grant, m0.err, tcount); end
   endtask

   task automatic test_reset_midtransfer();
      m0.cyc = 1; m0.stb = 1; m0.we = 1; m0.adr = 22'h000404; m0.dat_w = 32'h12345678; m0.sel = 4'hF;
      step();
      s.ack = 1;
      #1;
      n_checks++; if (grant !== 2'b01 || m0.ack !== 1'b1) begin n_fail++; $display("FAIL rm_before: grant=%b ack=%b want 01 1", grant, m0.ack); end
      #1;
      wb_rstn_i = 1'b0;
      #1;
      n_checks++; if (grant !== 2'b00 || s.cyc !== 1'b0 || s.stb !== 1'b0) begin n_fail++; $display("FAIL rm_async: grant=%b cyc=%b stb=%b want 00 0 0", grant, s.cyc, s.stb); end
      n_checks++; if (m0.ack !== 1'b0 || tcount !== 8'd0) begin n_fail++; $display("FAIL rm_async_resp: ack=%b count=%0d want 0 0", m0.ack, tcount); end
      @(negedge wb_clk_i);
      wb_rstn_i = 1'b1;
      s.ack = 0;
      step();
      n_checks++; if (grant !== 2'b01 || s.cyc !== 1'b1) begin n_fail++; $display("FAIL rm_regrant: grant=%b cyc=%b want 01 1", grant, s.cyc); end
      idle_all();
      step();
      step();
      n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL rm_idle: got %b want 00", grant); end
   endtask

   initial begin
      #200000;
      n_fail++;
      $display("FAIL global_time_limit: bench did not finish, %0d failures so far", n_fail);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single_write();
      test_round_robin();
      test_timeout_silent();
      test_timeout_ack_wins();
      test_drop_at_threshold();
      test_reset_midtransfer();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
